// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset level
// and the fetch FSM encoding.
package if_fetch_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam int   InstAddrBus = 32;
  localparam int   InstBus     = 32;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_KILL = 2'd2
  } if_state_e;

  function automatic logic rst_active(input logic rst);
    return rst == RstEnable;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO holding fetched {pc, word} pairs; flush empties it in
// one cycle and voids any concurrent push or pop.
module if_fifo
  import if_fetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign empty_o = (count_q == '0);
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Storage is cleared on reset so the head reads as zero straight out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst_active(rst)) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
          mem_q[gi] <= din_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_active(rst) || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding memory read at a time, results
// buffered with their PCs and handed to IF/ID over valid/ready.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_stall_o,
  input  logic              branch_flag_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  if_state_e         state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic [CNT_W:0]    occupancy;
  logic              inflight;
  logic              space;
  logic              fire;
  logic              push;
  logic              pop;

  // An in-flight request reserves a slot; a pop this cycle does not free one yet.
  assign inflight  = (state_q != IF_IDLE);
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign space     = occupancy < (CNT_W + 1)'(DEPTH);

  assign fire = !rst_active(rst) && !branch_flag_i && space &&
                ((state_q == IF_IDLE) || ((state_q == IF_WAIT) && mem_ack_i));

  assign pc_stall_o = !fire && !branch_flag_i;

  assign push = !rst_active(rst) && (state_q == IF_WAIT) && mem_ack_i && !branch_flag_i;
  assign pop  = !fifo_empty && inst_ready_i;

  always_ff @(posedge clk) begin
    if (rst_active(rst)) begin
      state_q    <= IF_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (fire) begin
            mem_addr_q <= pc_i;
            mem_req_q  <= 1'b1;
            state_q    <= IF_WAIT;
          end else begin
            mem_req_q  <= 1'b0;
          end
        end
        IF_WAIT: begin
          if (branch_flag_i) begin
            if (mem_ack_i) begin
              mem_req_q <= 1'b0;
              state_q   <= IF_IDLE;
            end else begin
              state_q   <= IF_KILL;
            end
          end else if (mem_ack_i) begin
            if (fire) begin
              mem_addr_q <= pc_i;
            end else begin
              mem_req_q  <= 1'b0;
              state_q    <= IF_IDLE;
            end
          end
        end
        IF_KILL: begin
          // The stale response must still be absorbed before refetching.
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= IF_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IF_IDLE;
        end
      endcase
    end
  end

  if_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (branch_flag_i),
    .din_i   ({mem_addr_q, mem_rdata_i}),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_head[DATA_W-1:0];
  assign inst_pc_o    = fifo_head[ENT_W-1 -: ADDR_W];

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch: a PC register, a latency-configurable memory
// and a queue-based reference of the fetch buffer, compared every cycle.
module tb_if_fetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_stall_o;
  logic        branch_flag_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  if_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_stall_o    (pc_stall_o),
    .branch_flag_i (branch_flag_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  typedef struct {
    int n;
    int rst_first;
    int lmin;
    int lmax;
    int rdy;
    int br;
    int rs;
    int spur;
  } phase_t;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Reference: buffered fetches, the one outstanding read, and the PC register.
  ent_t        q[$];
  bit          m_busy;
  bit          m_doomed;
  logic [31:0] m_addr;
  int          wait_cnt;
  int          lat_cur;
  logic [31:0] pc_reg;
  bit          just_reset;
  logic [31:0] br_target;

  phase_t ph[6];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit model_fire();
    bit has_space;
    has_space = (q.size() + (m_busy ? 1 : 0)) < DEPTH;
    return !rst && !branch_flag_i && has_space && (!m_busy || (!m_doomed && mem_ack_i));
  endfunction

  task automatic model_step(input int lmin, input int lmax);
    bit   f;
    bit   stall;
    bit   retire;
    ent_t e;
    f     = model_fire();
    stall = !f && !branch_flag_i;
    if (rst) begin
      q.delete();
      m_busy     = 1'b0;
      m_doomed   = 1'b0;
      m_addr     = '0;
      pc_reg     = '0;
      just_reset = 1'b1;
      return;
    end
    just_reset = 1'b0;
    retire = m_busy && mem_ack_i;
    if (branch_flag_i) begin
      q.delete();
    end else begin
      if (q.size() > 0 && inst_ready_i) begin
        $display("deliver pc=%h inst=%h cycle=%0d", q[0].pc, q[0].word, cyc);
        void'(q.pop_front());
      end
      if (retire && !m_doomed) begin
        e.pc   = m_addr;
        e.word = m_addr ^ KEY;
        q.push_back(e);
      end
    end
    if (f) begin
      m_busy   = 1'b1;
      m_doomed = 1'b0;
      m_addr   = pc_reg;
      wait_cnt = 0;
      lat_cur  = $urandom_range(lmin, lmax);
    end else if (retire) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (branch_flag_i) m_doomed = 1'b1;
      wait_cnt++;
    end
    if (branch_flag_i) pc_reg = br_target;
    else if (!stall) pc_reg = pc_reg + 32'd4;
  endtask

  task automatic drive(input phase_t p, input int k);
    rst           = (k < p.rst_first) || ($urandom_range(0, 99) < p.rs);
    branch_flag_i = !rst && ($urandom_range(0, 99) < p.br);
    br_target     = $urandom_range(0, 1) ? 32'h100 : {22'd0, 8'($urandom), 2'b00};
    inst_ready_i  = $urandom_range(0, 99) < p.rdy;
    pc_i          = pc_reg;
    if (m_busy) mem_ack_i = (wait_cnt >= lat_cur);
    else        mem_ack_i = $urandom_range(0, 99) < p.spur;
    mem_rdata_i = (m_busy && mem_ack_i) ? (m_addr ^ KEY) : $urandom;
  endtask

  task automatic compare();
    bit f;
    f = model_fire();
    check_val("pc_stall", 32'(pc_stall_o), 32'(!f && !branch_flag_i));
    check_val("mem_req", 32'(mem_req_o), 32'(m_busy));
    check_val("mem_addr", mem_addr_o, m_addr);
    check_val("inst_valid", 32'(inst_valid_o), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check_val("inst_pc", inst_pc_o, q[0].pc);
      check_val("inst", inst_o, q[0].word);
    end
    if (just_reset) begin
      check_val("rst_inst", inst_o, 32'h0);
      check_val("rst_inst_pc", inst_pc_o, 32'h0);
    end
    check_val("no_overflow", 32'(dut.u_fifo.count_o > DEPTH), 32'h0);
  endtask

  initial begin
    ph[0] = '{n: 40,  rst_first: 3, lmin: 0, lmax: 0, rdy: 100, br: 0,  rs: 0, spur: 0};
    ph[1] = '{n: 40,  rst_first: 0, lmin: 3, lmax: 3, rdy: 100, br: 0,  rs: 0, spur: 0};
    ph[2] = '{n: 12,  rst_first: 2, lmin: 0, lmax: 0, rdy: 0,   br: 0,  rs: 0, spur: 0};
    ph[3] = '{n: 20,  rst_first: 0, lmin: 0, lmax: 0, rdy: 100, br: 0,  rs: 0, spur: 0};
    ph[4] = '{n: 250, rst_first: 0, lmin: 0, lmax: 3, rdy: 70,  br: 8,  rs: 0, spur: 20};
    ph[5] = '{n: 250, rst_first: 0, lmin: 0, lmax: 2, rdy: 60,  br: 10, rs: 3, spur: 20};

    m_busy = 1'b0; m_doomed = 1'b0; m_addr = '0; wait_cnt = 0; lat_cur = 0;
    pc_reg = '0; just_reset = 1'b0; br_target = '0;
    rst = 1'b1; branch_flag_i = 1'b0; inst_ready_i = 1'b0; pc_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    @(posedge clk);
    #1;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < ph[p].n; k++) begin
        drive(ph[p], k);
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step(ph[p].lmin, ph[p].lmax);
        cyc++;
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
